hex_display_driver: RTL

HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

---
 rtl/hex_display_pkg.sv | 20 ++
 rtl/hex_display_driver_hex_to_7seg.sv | 14 +
 rtl/hex_display_driver.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared glyph constants and load FSM state type for the hex display driver.
package hex_display_pkg;

  localparam int unsigned SEG_W = 7;

  // Active-low segment pattern with every segment off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs for nibble values 0..F; bit 0 = a ... bit 6 = g.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } load_state_e;

endpackage

// File: rtl/hex_display_driver_hex_to_7seg.sv
// Combinational nibble-to-glyph decoder, shared by all digits during a load.
module hex_to_7seg
  import hex_display_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] glyph_c_o
);

  // Table lookup of the active-low glyph.
  always_comb begin
    glyph_c_o = GLYPH_TABLE[nibble_i];
  end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit 7-segment driver: accepts a hex value, writes digits one per
// cycle (most significant first) through one shared decoder, and drives
// registered active-low segments with per-digit blink and global blanking.
// Optional build macro HEX_DISPLAY_LZB_EN blanks leading zero digits
// (digit 0 is never blanked).
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = 12000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    enable,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] segments
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);

  load_state_e              state_q;
  logic                     ready_q;
  logic [IDX_W-1:0]         idx_q;
  logic [VAL_W-1:0]         value_q;
  logic [3:0]               nibble_d;
  logic [SEG_W-1:0]         dec_glyph;
  logic [SEG_W-1:0]         glyph_d;
  logic [SEG_W-1:0]         glyph_q [NUM_DIGITS];
  logic [CNT_W-1:0]         blink_cnt_q;
  logic                     blink_phase_q;
  logic [7*NUM_DIGITS-1:0]  segments_q;
`ifdef HEX_DISPLAY_LZB_EN
  logic                     lead_zero_q;
`endif

  // Load FSM: latch value on accept, then step digit index down to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      idx_q       <= '0;
      value_q     <= '0;
`ifdef HEX_DISPLAY_LZB_EN
      lead_zero_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (value_valid) begin
            value_q     <= value_in;
            idx_q       <= LAST_IDX;
            state_q     <= ST_LOAD;
            ready_q     <= 1'b0;
`ifdef HEX_DISPLAY_LZB_EN
            lead_zero_q <= 1'b1;
`endif
          end
        end
        ST_LOAD: begin
`ifdef HEX_DISPLAY_LZB_EN
          if (nibble_d != 4'h0) begin
            lead_zero_q <= 1'b0;
          end
`endif
          if (idx_q == '0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Select the nibble of the digit currently being written.
  always_comb begin
    nibble_d = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble_d = value_q[4*i +: 4];
      end
    end
  end

  hex_to_7seg u_dec (
    .nibble_i  (nibble_d),
    .glyph_c_o (dec_glyph)
  );

  // Glyph to store for the current digit, with optional leading-zero blanking.
  always_comb begin
`ifdef HEX_DISPLAY_LZB_EN
    glyph_d = (lead_zero_q && (nibble_d == 4'h0) && (idx_q != '0)) ? SEG_BLANK : dec_glyph;
`else
    glyph_d = dec_glyph;
`endif
  end

  // Glyph store: one digit written per LOAD cycle; others keep their glyph.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        glyph_q[i] <= SEG_BLANK;
      end
    end else if (state_q == ST_LOAD) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          glyph_q[i] <= glyph_d;
        end
      end
    end
  end

  // Free-running blink divider; phase flips on each wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + CNT_W'(1);
    end
  end

  // Registered segment outputs with enable and blink blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      segments_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        segments_q[7*i +: 7] <= (!enable || (blink_phase_q && blink_mask[i])) ? SEG_BLANK : glyph_q[i];
      end
    end
  end

  assign value_ready = ready_q;
  assign segments    = segments_q;

endmodule
